mips_multicycle_control: RTL and testbench

MIPS_MULTICYCLE_CONTROL -- requirements
Module: mips_multicycle_control

---
 rtl/mips_pkg.sv | 47 ++++
 rtl/mips_ctrl_wait_timer.sv | 22 ++
 rtl/mips_multicycle_control.sv | 120 ++++++++++++
 tb/tb_mips_multicycle_control.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: shared opcodes, FSM state codes, alu_op and trap_cause encodings.
// Optional feature: MIPS_CTRL_BNE_EN makes the dispatch function route bne to BRANCH.
package mips_pkg;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEM_ADDR = 4'd2;
    localparam logic [3:0] S_MEM_RD   = 4'd3;
    localparam logic [3:0] S_MEM_WB   = 4'd4;
    localparam logic [3:0] S_MEM_WR   = 4'd5;
    localparam logic [3:0] S_R_EXEC   = 4'd6;
    localparam logic [3:0] S_R_WB     = 4'd7;
    localparam logic [3:0] S_I_EXEC   = 4'd8;
    localparam logic [3:0] S_I_WB     = 4'd9;
    localparam logic [3:0] S_BRANCH   = 4'd10;
    localparam logic [3:0] S_JUMP     = 4'd11;
    localparam logic [3:0] S_TRAP     = 4'd12;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

    function automatic logic [3:0] dispatch(input logic [5:0] op);
        logic w_bne;
`ifdef MIPS_CTRL_BNE_EN
        w_bne = (op == OP_BNE);
`else
        w_bne = 1'b0;
`endif
        return (op == OP_RTYPE)                ? S_R_EXEC   :
               (op == OP_LW || op == OP_SW)    ? S_MEM_ADDR :
               (op == OP_ADDI)                 ? S_I_EXEC   :
               (op == OP_BEQ || w_bne)         ? S_BRANCH   :
               (op == OP_J)                    ? S_JUMP     : S_TRAP;
    endfunction
endpackage

// File: rtl/mips_ctrl_wait_timer.sv
// mips_ctrl_wait_timer: counts consecutive memory wait cycles and flags a timeout.
module mips_ctrl_wait_timer #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_active,
    input  logic i_ready,
    output logic o_timeout
);
    logic [7:0] r_cnt;

    // Count not-ready cycles; completion or leaving a memory state restarts from zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_cnt <= '0;
        else
            r_cnt <= (i_active && !i_ready) ? r_cnt + 8'd1 : 8'd0;
    end

    assign o_timeout = i_active && !i_ready && (r_cnt == 8'(MEM_TIMEOUT - 1));
endmodule

// File: rtl/mips_multicycle_control.sv
// mips_multicycle_control: multicycle MIPS control FSM with memory timeout and illegal-opcode trap.
// Optional feature: define MIPS_CTRL_BNE_EN to execute bne through the BRANCH state.
module mips_multicycle_control
    import mips_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       ir_write,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic [3:0] state,
    output logic       trap,
    output logic [1:0] trap_cause
);
    logic [3:0] r_state;
    logic       r_run;
    logic       r_trap;
    logic [1:0] r_cause;
    logic [3:0] w_next;
    logic       w_timeout;
    logic       w_take;
    logic       w_unused_funct;
    logic w_fetch, w_decode, w_mem_addr, w_mem_rd, w_mem_wb, w_mem_wr;
    logic w_r_exec, w_r_wb, w_i_exec, w_i_wb, w_branch, w_jump;

    assign w_unused_funct = ^funct;

    // r_run holds every output low from reset until the first clock after release.
    assign w_fetch    = r_run && r_state == S_FETCH;
    assign w_decode   = r_run && r_state == S_DECODE;
    assign w_mem_addr = r_run && r_state == S_MEM_ADDR;
    assign w_mem_rd   = r_run && r_state == S_MEM_RD;
    assign w_mem_wb   = r_run && r_state == S_MEM_WB;
    assign w_mem_wr   = r_run && r_state == S_MEM_WR;
    assign w_r_exec   = r_run && r_state == S_R_EXEC;
    assign w_r_wb     = r_run && r_state == S_R_WB;
    assign w_i_exec   = r_run && r_state == S_I_EXEC;
    assign w_i_wb     = r_run && r_state == S_I_WB;
    assign w_branch   = r_run && r_state == S_BRANCH;
    assign w_jump     = r_run && r_state == S_JUMP;

`ifdef MIPS_CTRL_BNE_EN
    assign w_take = (opcode == OP_BNE) ? !zero : zero;
`else
    assign w_take = zero;
`endif

    mips_ctrl_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
        .clk       (clk),
        .rst_n     (reset),
        .i_active  (w_fetch || w_mem_rd || w_mem_wr),
        .i_ready   (mem_ready),
        .o_timeout (w_timeout)
    );

    // Next state; mem_ready is tested before the timeout so completion wins a tie.
    always_comb begin
        w_next = r_state;
        if (r_run)
            case (r_state)
                S_FETCH:    w_next = mem_ready ? S_DECODE : w_timeout ? S_TRAP : S_FETCH;
                S_DECODE:   w_next = dispatch(opcode);
                S_MEM_ADDR: w_next = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
                S_MEM_RD:   w_next = mem_ready ? S_MEM_WB : w_timeout ? S_TRAP : S_MEM_RD;
                S_MEM_WR:   w_next = mem_ready ? S_FETCH : w_timeout ? S_TRAP : S_MEM_WR;
                S_R_EXEC:   w_next = S_R_WB;
                S_I_EXEC:   w_next = S_I_WB;
                S_TRAP:     w_next = S_TRAP;
                default:    w_next = S_FETCH;
            endcase
    end

    // State register, run qualifier and sticky trap record captured on entry to TRAP.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_FETCH;
            r_run   <= 1'b0;
            r_trap  <= 1'b0;
            r_cause <= CAUSE_NONE;
        end else begin
            r_run   <= 1'b1;
            r_state <= w_next;
            if (w_next == S_TRAP && r_state != S_TRAP) begin
                r_trap  <= 1'b1;
                r_cause <= (r_state == S_DECODE) ? CAUSE_ILLEGAL : CAUSE_TIMEOUT;
            end
        end
    end

    assign pc_write   = (w_fetch && mem_ready) || w_jump || (w_branch && w_take);
    assign ir_write   = w_fetch && mem_ready;
    assign i_or_d     = w_mem_rd || w_mem_wr;
    assign mem_read   = w_fetch || w_mem_rd;
    assign mem_write  = w_mem_wr;
    assign mem_to_reg = w_mem_wb;
    assign reg_dst    = w_r_wb;
    assign reg_write  = w_mem_wb || w_r_wb || w_i_wb;
    assign alu_src_a  = w_mem_addr || w_r_exec || w_i_exec || w_branch;
    assign alu_src_b  = w_fetch ? 2'b01 : w_decode ? 2'b11 : (w_mem_addr || w_i_exec) ? 2'b10 : 2'b00;
    assign alu_op     = w_r_exec ? ALU_FUNCT : w_branch ? ALU_SUB : ALU_ADD;
    assign pc_source  = w_branch ? 2'b01 : w_jump ? 2'b10 : 2'b00;
    assign state      = r_state;
    assign trap       = r_trap;
    assign trap_cause = r_cause;
endmodule

// File: tb/tb_mips_multicycle_control.sv
// tb_mips_multicycle_control: directed scoreboard bench for the multicycle MIPS control FSM.
module tb_mips_multicycle_control;
  import mips_pkg::*;
  localparam logic [14:0] C_NONE = 15'b000000000_00_00_00;
  localparam logic [14:0] C_FWT  = 15'b000100000_01_00_00;
  localparam logic [14:0] C_FRDY = 15'b110100000_01_00_00;
  localparam logic [14:0] C_DEC  = 15'b000000000_11_00_00;
  localparam logic [14:0] C_MA   = 15'b000000001_10_00_00;
  localparam logic [14:0] C_MRD  = 15'b001100000_00_00_00;
  localparam logic [14:0] C_MWB  = 15'b000001010_00_00_00;
  localparam logic [14:0] C_MWR  = 15'b001010000_00_00_00;
  localparam logic [14:0] C_REX  = 15'b000000001_00_10_00;
  localparam logic [14:0] C_RWB  = 15'b000000110_00_00_00;
  localparam logic [14:0] C_IEX  = 15'b000000001_10_00_00;
  localparam logic [14:0] C_IWB  = 15'b000000010_00_00_00;
  localparam logic [14:0] C_BR0  = 15'b000000001_00_01_01;
  localparam logic [14:0] C_BR1  = 15'b100000001_00_01_01;
  localparam logic [14:0] C_JMP  = 15'b100000000_00_00_10;
  typedef struct {
    string       name;
    logic [3:0]  st;
    logic [14:0] ctl;
    logic        tr;
    logic [1:0]  tc;
  } exp_t;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [5:0] opcode = 6'd0;
  logic [5:0] funct = 6'h20;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic pc_write, ir_write, i_or_d, mem_read, mem_write, mem_to_reg, reg_dst, reg_write, alu_src_a;
  logic [1:0] alu_src_b, alu_op, pc_source, trap_cause;
  logic [3:0] state;
  logic       trap;
  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  mips_multicycle_control #(.MEM_TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .ir_write(ir_write), .i_or_d(i_or_d), .mem_read(mem_read),
    .mem_write(mem_write), .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_source(pc_source),
    .state(state), .trap(trap), .trap_cause(trap_cause)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin : monitor
    exp_t e;
    logic [14:0] a;
    a = {pc_write, ir_write, i_or_d, mem_read, mem_write, mem_to_reg, reg_dst, reg_write,
         alu_src_a, alu_src_b, alu_op, pc_source};
    while (q.size() > 0) begin
      e = q.pop_front();
      checks++;
      if (state !== e.st || a !== e.ctl || trap !== e.tr || trap_cause !== e.tc) begin
        errors++;
        $display("FAIL %s: got state=%0d ctl=%b trap=%b cause=%b, want state=%0d ctl=%b trap=%b cause=%b",
                 e.name, state, a, trap, trap_cause, e.st, e.ctl, e.tr, e.tc);
      end
    end
  end
  task automatic cyc(input string n, input logic [3:0] st, input logic [14:0] ctl,
                     input logic tr = 1'b0, input logic [1:0] tc = 2'b00);
    q.push_back('{name: n, st: st, ctl: ctl, tr: tr, tc: tc});
    @(posedge clk);
    #1;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end
  initial begin
    @(posedge clk);
    #1;
    cyc("reset_hold", S_FETCH, C_NONE);
    reset = 1'b1;
    cyc("reset_release", S_FETCH, C_NONE);
    opcode = OP_RTYPE; mem_ready = 1'b1;
    cyc("add_fetch", S_FETCH, C_FRDY);
    cyc("add_decode", S_DECODE, C_DEC);
    cyc("add_exec", S_R_EXEC, C_REX);
    cyc("add_wb_cycle4", S_R_WB, C_RWB);
    opcode = OP_LW;
    cyc("add_fetch_cycle5", S_FETCH, C_FRDY);
    cyc("lw_decode", S_DECODE, C_DEC);
    cyc("lw_addr", S_MEM_ADDR, C_MA);
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) cyc("lw_rd_wait", S_MEM_RD, C_MRD);
    mem_ready = 1'b1;
    cyc("lw_rd_done", S_MEM_RD, C_MRD);
    cyc("lw_wb", S_MEM_WB, C_MWB);
    opcode = OP_ADDI;
    cyc("addi_fetch", S_FETCH, C_FRDY);
    cyc("addi_decode", S_DECODE, C_DEC);
    cyc("addi_exec", S_I_EXEC, C_IEX);
    cyc("addi_wb", S_I_WB, C_IWB);
    opcode = OP_BEQ; zero = 1'b0;
    cyc("beq0_fetch", S_FETCH, C_FRDY);
    cyc("beq0_decode", S_DECODE, C_DEC);
    cyc("beq0_branch", S_BRANCH, C_BR0);
    zero = 1'b1;
    cyc("beq1_fetch", S_FETCH, C_FRDY);
    cyc("beq1_decode", S_DECODE, C_DEC);
    cyc("beq1_branch", S_BRANCH, C_BR1);
    zero = 1'b0; opcode = OP_J;
    cyc("j_fetch", S_FETCH, C_FRDY);
    cyc("j_decode", S_DECODE, C_DEC);
    cyc("j_jump", S_JUMP, C_JMP);
    opcode = OP_SW;
    cyc("sw_fetch", S_FETCH, C_FRDY);
    cyc("sw_decode", S_DECODE, C_DEC);
    cyc("sw_addr", S_MEM_ADDR, C_MA);
    mem_ready = 1'b0;
    cyc("sw_wr_wait", S_MEM_WR, C_MWR);
    reset = 1'b0;
    #1;
    checks++;
    if (mem_write !== 1'b0 || state !== S_FETCH) begin
      errors++;
      $display("FAIL sw_reset_immediate: mem_write=%b state=%0d", mem_write, state);
    end
    cyc("sw_reset_mid", S_FETCH, C_NONE);
    reset = 1'b1;
    cyc("sw_after_release", S_FETCH, C_NONE);
    for (int i = 0; i < 3; i++) cyc("to_wait", S_FETCH, C_FWT);
    opcode = OP_J; mem_ready = 1'b1;
    cyc("to_ready_4th", S_FETCH, C_FRDY);
    cyc("to_decode", S_DECODE, C_DEC);
    cyc("to_jump", S_JUMP, C_JMP);
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) cyc("tt_wait", S_FETCH, C_FWT);
    cyc("tt_trap", S_TRAP, C_NONE, 1'b1, CAUSE_TIMEOUT);
    mem_ready = 1'b1;
    cyc("tt_trap_hold", S_TRAP, C_NONE, 1'b1, CAUSE_TIMEOUT);
    reset = 1'b0;
    cyc("ill_reset_clears", S_FETCH, C_NONE);
    reset = 1'b1;
    cyc("ill_release", S_FETCH, C_NONE);
    opcode = 6'b111111;
    cyc("ill_fetch", S_FETCH, C_FRDY);
    cyc("ill_decode", S_DECODE, C_DEC);
    for (int i = 0; i < 21; i++) begin
      mem_ready = i[0];
      zero = i[1];
      cyc("ill_trap", S_TRAP, C_NONE, 1'b1, CAUSE_ILLEGAL);
    end
    reset = 1'b0;
    cyc("bne_reset", S_FETCH, C_NONE);
    reset = 1'b1; zero = 1'b0; mem_ready = 1'b1;
    cyc("bne_release", S_FETCH, C_NONE);
    opcode = OP_BNE;
    cyc("bne_fetch", S_FETCH, C_FRDY);
    cyc("bne_decode", S_DECODE, C_DEC);
`ifdef MIPS_CTRL_BNE_EN
    cyc("bne_branch", S_BRANCH, C_BR1);
`else
    cyc("bne_illegal", S_TRAP, C_NONE, 1'b1, CAUSE_ILLEGAL);
`endif
    @(negedge clk);
    if (checks < 12) begin
      errors++;
      $display("FAIL too few checks ran: %0d", checks);
    end
    if (errors != 0) $display("FAIL: %0d errors", errors);
    else $display("PASS");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
